// File: rtl/alu_pkg.sv
// Shared opcode constants, FSM encoding and opcode helpers for the ALU issue stage.
package alu_pkg;

    localparam int unsigned ALU_AND  = 1;
    localparam int unsigned ALU_OR   = 2;
    localparam int unsigned ALU_NOT  = 3;
    localparam int unsigned ALU_XOR  = 4;
    localparam int unsigned ALU_NOR  = 5;
    localparam int unsigned ALU_NEG  = 6;
    localparam int unsigned ALU_ROL  = 7;
    localparam int unsigned ALU_ROR  = 8;
    localparam int unsigned ALU_SHL  = 9;
    localparam int unsigned ALU_SHR  = 10;
    localparam int unsigned ALU_SHRA = 11;
    localparam int unsigned ALU_ADD  = 12;
    localparam int unsigned ALU_SUB  = 13;
    localparam int unsigned ALU_MUL  = 14;
    localparam int unsigned ALU_DIV  = 15;

    localparam int unsigned SEL_ARG_W = 32;
    localparam int unsigned LAT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // Opcodes that need the multi-cycle execute window.
    function automatic logic is_muldiv(input logic [SEL_ARG_W-1:0] sel);
        return (sel == SEL_ARG_W'(ALU_MUL)) || (sel == SEL_ARG_W'(ALU_DIV));
    endfunction

    function automatic logic is_legal(input logic [SEL_ARG_W-1:0] sel);
        return (sel >= SEL_ARG_W'(ALU_AND)) && (sel <= SEL_ARG_W'(ALU_DIV));
    endfunction

endpackage

// File: rtl/alu_lat_counter.sv
// Loadable down-counter that paces the execute window; zero_c flags expiry.
module alu_lat_counter
    import alu_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 en,
    input  logic [LAT_CNT_W-1:0] load_val,
    output logic                 zero_c
);

    logic [LAT_CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - LAT_CNT_W'(1);
        end
    end

    assign zero_c = (count == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// Issue stage: registers one request onto the external ALU, waits out its latency,
// then holds the captured result until downstream takes it.
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned SEL_WIDTH  = 16,
    parameter int unsigned MULDIV_LAT = 4
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] op_a,
    input  logic [DATA_WIDTH-1:0] op_b,
    input  logic [SEL_WIDTH-1:0]  op_sel,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [SEL_WIDTH-1:0]  alu_Sel,
    input  logic [DATA_WIDTH-1:0] alu_ZHigh,
    input  logic [DATA_WIDTH-1:0] alu_ZLow,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] z_high,
    output logic [DATA_WIDTH-1:0] z_low,
    output logic                  err
);

    localparam logic [LAT_CNT_W-1:0] MD_LOAD = LAT_CNT_W'(MULDIV_LAT - 1);

    state_t state, state_nxt;
    logic   accept, capture, done;
    logic   cnt_zero, cnt_en;
    logic [LAT_CNT_W-1:0] cnt_load_val;

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) state <= ST_IDLE;
        else        state <= state_nxt;
    end

    // Next-state and handshake strobes.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        accept    = 1'b0;
        capture   = 1'b0;
        done      = 1'b0;
        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept    = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_zero) begin
                    capture   = 1'b1;
                    state_nxt = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    done      = 1'b1;
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign cnt_en       = (state == ST_EXEC) && !cnt_zero;
    assign cnt_load_val = is_muldiv(SEL_ARG_W'(op_sel)) ? MD_LOAD : '0;

    alu_lat_counter u_lat_counter (
        .clk      (clock),
        .rst_n    (clear),
        .load     (accept),
        .en       (cnt_en),
        .load_val (cnt_load_val),
        .zero_c   (cnt_zero)
    );

    // Operand launch, result capture and output valid.
    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            alu_A     <= '0;
            alu_B     <= '0;
            alu_Sel   <= '0;
            z_high    <= '0;
            z_low     <= '0;
            err       <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            if (accept) begin
                alu_A   <= op_a;
                alu_B   <= op_b;
                alu_Sel <= op_sel;
            end
            if (capture) begin
                alu_Sel   <= '0;
                out_valid <= 1'b1;
                if (is_legal(SEL_ARG_W'(alu_Sel))) begin
                    z_high <= alu_ZHigh;
                    z_low  <= alu_ZLow;
                    err    <= 1'b0;
                end else begin
                    z_high <= '0;
                    z_low  <= '0;
                    err    <= 1'b1;
                end
            end
            if (done) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage with a behavioural ALU on the far side.
module tb_alu_issue_stage;

    logic        clock = 1'b0;
    logic        clear;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] op_a, op_b;
    logic [15:0] op_sel;
    logic [31:0] alu_A, alu_B;
    logic [15:0] alu_Sel;
    logic [31:0] alu_ZHigh, alu_ZLow;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] z_high, z_low;
    logic        err;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clock = ~clock;

    alu_issue_stage #(.DATA_WIDTH(32), .SEL_WIDTH(16), .MULDIV_LAT(4)) dut (
        .clock     (clock),
        .clear     (clear),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .op_sel    (op_sel),
        .alu_A     (alu_A),
        .alu_B     (alu_B),
        .alu_Sel   (alu_Sel),
        .alu_ZHigh (alu_ZHigh),
        .alu_ZLow  (alu_ZLow),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .z_high    (z_high),
        .z_low     (z_low),
        .err       (err)
    );

    // Behavioural ALU; unmodelled opcodes echo operands so zeroing is observable.
    always_comb begin
        logic [63:0] prod;
        prod      = 64'(alu_A) * 64'(alu_B);
        alu_ZHigh = alu_A;
        alu_ZLow  = alu_B;
        case (alu_Sel)
            16'd4:  begin alu_ZHigh = '0; alu_ZLow = alu_A ^ alu_B; end
            16'd12: begin alu_ZHigh = '0; alu_ZLow = alu_A + alu_B; end
            16'd13: begin alu_ZHigh = '0; alu_ZLow = alu_A - alu_B; end
            16'd14: begin alu_ZHigh = prod[63:32]; alu_ZLow = prod[31:0]; end
            16'd15: begin
                alu_ZHigh = (alu_B != 0) ? alu_A % alu_B : '0;
                alu_ZLow  = (alu_B != 0) ? alu_A / alu_B : '0;
            end
            default: ;
        endcase
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic [15:0] sel);
        op_a     = a;
        op_b     = b;
        op_sel   = sel;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
    endtask

    // Cycles from the accept edge until out_valid, bounded at 20.
    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 20) begin
            step();
            n++;
        end
    endtask

    task automatic retire();
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
    endtask

    initial begin
        int  lat;
        logic saw_valid;
        clear     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sel    = '0;
        step();
        step();

        check("rst_in_ready",  64'(in_ready),  64'd1);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_alu_sel",   64'(alu_Sel),   64'd0);
        check("rst_alu_a",     64'(alu_A),     64'd0);
        check("rst_z",         {z_high, z_low}, 64'd0);
        check("rst_err",       64'(err),       64'd0);

        // Add on the first edge after reset release.
        clear = 1'b1;
        issue(32'd7, 32'd5, 16'd12);
        check("add_alu_sel",  64'(alu_Sel),  64'd12);
        check("add_alu_a",    64'(alu_A),    64'd7);
        check("add_in_ready", 64'(in_ready), 64'd0);
        check("add_ov_early", 64'(out_valid), 64'd0);
        wait_result(lat);
        check("add_lat",    64'(lat),    64'd1);
        check("add_z_low",  64'(z_low),  64'd12);
        check("add_z_high", 64'(z_high), 64'd0);
        check("add_err",    64'(err),    64'd0);
        check("hold_alu_sel", 64'(alu_Sel), 64'd0);
        step();
        check("add_held", 64'(out_valid), 64'd1);
        retire();
        check("add_ov_drop",  64'(out_valid), 64'd0);
        check("add_retained", 64'(z_low),     64'd12);
        check("idle_ready",   64'(in_ready),  64'd1);

        // out_ready in IDLE does nothing.
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("idle_oready", 64'(out_valid), 64'd0);

        issue(32'd6, 32'd7, 16'd14);
        wait_result(lat);
        check("mul_lat", 64'(lat), 64'd4);
        check("mul_z",   {z_high, z_low}, 64'd42);
        retire();

        issue(32'h0001_0000, 32'h0001_0000, 16'd14);
        wait_result(lat);
        check("mul_hi_lat", 64'(lat), 64'd4);
        check("mul_hi_z",   {z_high, z_low}, 64'h0000_0001_0000_0000);
        retire();

        issue(32'd100, 32'd7, 16'd15);
        wait_result(lat);
        check("div_lat", 64'(lat), 64'd4);
        check("div_z",   {z_high, z_low}, {32'd2, 32'd14});
        retire();

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 16'd0);
        wait_result(lat);
        check("ill0_lat", 64'(lat), 64'd1);
        check("ill0_z",   {z_high, z_low}, 64'd0);
        check("ill0_err", 64'(err), 64'd1);
        retire();

        issue(32'h1234_5678, 32'h9ABC_DEF0, 16'd16);
        wait_result(lat);
        check("ill16_lat", 64'(lat), 64'd1);
        check("ill16_z",   {z_high, z_low}, 64'd0);
        check("ill16_err", 64'(err), 64'd1);
        retire();

        // Held result ignores a pending request until downstream accepts.
        issue(32'hF0, 32'h0F, 16'd4);
        wait_result(lat);
        check("xor_err", 64'(err), 64'd0);
        op_a     = 32'd10;
        op_b     = 32'd3;
        op_sel   = 16'd13;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            check("stall_ov",    64'(out_valid), 64'd1);
            check("stall_ready", 64'(in_ready),  64'd0);
            check("stall_z",     64'(z_low),     64'hFF);
            step();
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check("stall_rel_ov",    64'(out_valid), 64'd0);
        check("stall_rel_ready", 64'(in_ready),  64'd1);
        step();
        in_valid = 1'b0;
        check("second_sel", 64'(alu_Sel), 64'd13);
        check("second_a",   64'(alu_A),   64'd10);
        wait_result(lat);
        check("second_lat", 64'(lat),   64'd1);
        check("second_z",   64'(z_low), 64'd7);
        retire();

        // Abort a multiply mid-execute.
        issue(32'd6, 32'd7, 16'd14);
        step();
        clear = 1'b0;
        #1;
        check("abort_ov",    64'(out_valid), 64'd0);
        check("abort_z",     {z_high, z_low}, 64'd0);
        check("abort_alu",   {alu_A, alu_B}, 64'd0);
        check("abort_sel",   64'(alu_Sel), 64'd0);
        check("abort_err",   64'(err), 64'd0);
        check("abort_ready", 64'(in_ready), 64'd1);
        step();
        clear     = 1'b1;
        saw_valid = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (out_valid) saw_valid = 1'b1;
        end
        check("abort_no_result", 64'(saw_valid), 64'd0);
        issue(32'd2, 32'd3, 16'd12);
        wait_result(lat);
        check("post_abort_lat", 64'(lat),   64'd1);
        check("post_abort_z",   64'(z_low), 64'd5);
        check("post_abort_err", 64'(err),   64'd0);
        retire();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
